lsu_fifo_v2: RTL

Parametrised synchronous FIFO between LSU request issue and the memory/bus port; successor of the fixed-depth LSU queue.
- Generalises data width and depth; depth need not be a power of two.
- Adds flush, occupancy level, almost-full watermark, a sticky overflow flag, and push-while-full when a pop happens in the same cycle.
- One clock domain; sits between LSU address/data generation and the bus master.

---
 rtl/lsu_fifo_pkg.sv | 21 ++
 rtl/lsu_fifo_ram.sv | 29 ++
 rtl/lsu_fifo_v2.sv | 117 +++++++++++
 3 files changed

// File: rtl/lsu_fifo_pkg.sv
// rtl/lsu_fifo_pkg.sv - shared widths and level-update encoding for lsu_fifo_v2
package lsu_fifo_pkg;

  // Pointer width for a storage array of 'depth' entries (at least 1 bit)
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Counter width able to hold 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // How the occupancy counter moves in a given cycle
  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_INC  = 2'd1,
    LVL_DEC  = 2'd2
  } lvl_op_e;

endpackage

// File: rtl/lsu_fifo_ram.sv
// rtl/lsu_fifo_ram.sv - DEPTH x DATA_W register array, one write port, async read
module lsu_fifo_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read of the addressed entry
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/lsu_fifo_v2.sv
// rtl/lsu_fifo_v2.sv - LSU request FIFO with flush, level, watermark, overflow; optional LSU_FIFO_BYPASS_EN
module lsu_fifo_v2
  import lsu_fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              push_i,
  output logic              accept_o,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  level_o,
  output logic              almost_full_o,
  output logic              overflow_o
);

  localparam int                PTR_W    = ptr_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  level;
  logic              overflow;
  logic [DATA_W-1:0] ram_rdata;
  logic              empty;
  logic              full;
  logic              push_ok;
  logic              store;
  logic              pop_mem;
  logic              ram_we;
  lvl_op_e           lvl_op;

  // Handshake, head selection and level-move decode from registered state
  always_comb begin
    empty    = (level == '0);
    full     = (level == FULL_LVL);
    // A pop in the same cycle frees the slot a full queue needs
    accept_o = !full | pop_i;
    push_ok  = push_i & accept_o;
    // Only a stored entry advances the read pointer
    pop_mem  = pop_i & !empty;
`ifdef LSU_FIFO_BYPASS_EN
    // Empty queue forwards the incoming entry; if it is popped too it is never stored
    valid_o  = !empty | push_i;
    data_o   = empty ? data_i : ram_rdata;
    store    = push_ok & !(empty & pop_i);
`else
    valid_o  = !empty;
    data_o   = ram_rdata;
    store    = push_ok;
`endif
    if (store & !pop_mem) begin
      lvl_op = LVL_INC;
    end else if (pop_mem & !store) begin
      lvl_op = LVL_DEC;
    end else begin
      lvl_op = LVL_HOLD;
    end
    almost_full_o = (level >= AF_LVL);
    level_o       = level;
    overflow_o    = overflow;
    ram_we        = store & !rst_i & !flush_i;
  end

  // Pointer, level and sticky overflow state; reset beats flush beats normal operation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_mem) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case (lvl_op)
        LVL_INC: level <= level + 1'b1;
        LVL_DEC: level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push_i & !accept_o) begin
        overflow <= 1'b1;
      end
    end
  end

  lsu_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk_i  (clk_i),
    .we     (ram_we),
    .waddr  (wr_ptr),
    .wdata  (data_i),
    .raddr  (rd_ptr),
    .rdata  (ram_rdata)
  );

endmodule
